// File: rtl/cmd_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_dispatch_pkg
// Purpose  : Shared frame field positions, FSM state codes and helpers for
//            the command dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package cmd_dispatch_pkg;

  // Header word layout: [31:24] count/nargs, [CMD_BITS-1:0] code/cmd
  localparam int NARGS_LSB  = 24;
  localparam int NARGS_BITS = 8;
  localparam int CODE_LSB   = 0;

  // Response code reported when a unit never signals completion
  localparam logic [7:0] RSP_TIMEOUT_DEFAULT = 8'hff;

  // Dispatcher FSM state codes
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ARGS     = 3'd1;
  localparam state_t ST_DRAIN    = 3'd2;
  localparam state_t ST_EXEC     = 3'd3;
  localparam state_t ST_RSP_HDR  = 3'd4;
  localparam state_t ST_RSP_BODY = 3'd5;

  // Build a response header; code_ext must already be masked to CMD_BITS
  function automatic logic [31:0] make_rsp_hdr(input logic [7:0]  count,
                                               input logic [31:0] code_ext);
    return ({24'd0, count} << NARGS_LSB) | (code_ext << CODE_LSB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_dispatch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with first-word-fall-through head, flush and
//            occupancy count. Push when full and pop when empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (count_q == CW'(DEPTH));
  assign w_empty = (count_q == '0);
  assign w_push  = push_i && !w_full;
  assign w_pop   = pop_i && !w_empty;

  // Pointer and occupancy tracking; flush discards everything
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (w_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = w_empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : cmd_dispatch
// Purpose  : Parses the host command stream into command frames, buffers the
//            arguments for the units, collects their response words and
//            returns them as response frames. One command at a time, with
//            involuntary-message arbitration and a per-command timeout.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int                  CMD_BITS    = 8,
  parameter int                  ARG_DEPTH   = 16,
  parameter int                  RSP_DEPTH   = 16,
  parameter int                  TIMEOUT     = 65535,
  parameter logic [CMD_BITS-1:0] RSP_TIMEOUT = CMD_BITS'(RSP_TIMEOUT_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CMD_BITS-1:0] cmd,
  output logic                cmd_ready,
  output logic [31:0]         arg_data,
  input  logic                arg_advance,
  input  logic                cmd_done,
  input  logic [31:0]         param_data,
  input  logic                param_write,
  input  logic                invol_req,
  output logic                invol_grant,
  output logic                err_overflow,
  output logic                err_timeout
);

  localparam int          ACW       = $clog2(ARG_DEPTH) + 1;
  localparam int          RCW       = $clog2(RSP_DEPTH) + 1;
  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [8:0]  ARG_LIMIT = 9'(ARG_DEPTH);

  state_t                state_q, state_d;
  logic [NARGS_BITS-1:0] remaining_q, remaining_d;
  logic [CMD_BITS-1:0]   cmd_q, cmd_d;
  logic [CMD_BITS-1:0]   code_q, code_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  grant_q, grant_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_to_q, err_to_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic                  w_arg_push, w_arg_pop, w_arg_flush;
  logic                  w_rsp_push, w_rsp_pop, w_rsp_flush;
  logic [31:0]           w_arg_head, w_rsp_head;
  logic [ACW-1:0]        w_arg_count;
  logic [RCW-1:0]        w_rsp_count;
  logic                  w_in_ready, w_out_valid;
  logic [31:0]           w_out_data;
  logic [NARGS_BITS-1:0] w_nargs;

  assign w_nargs   = in_data[NARGS_LSB +: NARGS_BITS];
  assign w_arg_pop = arg_advance && (w_arg_count != '0);

  sync_fifo #(.WIDTH(32), .DEPTH(ARG_DEPTH)) u_arg_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (w_arg_flush),
    .push_i  (w_arg_push),
    .data_i  (in_data),
    .pop_i   (w_arg_pop),
    .head_o  (w_arg_head),
    .count_o (w_arg_count)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (w_rsp_flush),
    .push_i  (w_rsp_push),
    .data_i  (param_data),
    .pop_i   (w_rsp_pop),
    .head_o  (w_rsp_head),
    .count_o (w_rsp_count)
  );

  // Frame parsing, execution tracking and response emission
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cmd_d       = cmd_q;
    code_d      = code_q;
    cmd_ready_d = 1'b0;
    grant_d     = grant_q;
    err_ovf_d   = err_ovf_q;
    err_to_d    = err_to_q;
    timer_d     = timer_q;
    w_arg_push  = 1'b0;
    w_arg_flush = 1'b0;
    w_rsp_push  = 1'b0;
    w_rsp_pop   = 1'b0;
    w_rsp_flush = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_data  = '0;

    case (state_q)
      ST_IDLE: begin
        if (invol_req) begin
          // Unsolicited message wins over a waiting header
          grant_d = 1'b1;
          timer_d = '0;
          state_d = ST_EXEC;
        end else begin
          w_in_ready = 1'b1;
          if (in_valid) begin
            cmd_d       = in_data[CMD_BITS-1:0];
            remaining_d = w_nargs;
            if ({1'b0, w_nargs} > ARG_LIMIT) begin
              err_ovf_d = 1'b1;
              state_d   = ST_DRAIN;
            end else if (w_nargs == '0) begin
              cmd_ready_d = 1'b1;
              timer_d     = '0;
              state_d     = ST_EXEC;
            end else begin
              state_d = ST_ARGS;
            end
          end
        end
      end

      ST_ARGS: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_arg_push  = 1'b1;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            cmd_ready_d = 1'b1;
            timer_d     = '0;
            state_d     = ST_EXEC;
          end
        end
      end

      ST_DRAIN: begin
        // Oversized frame: swallow its arguments without executing
        w_in_ready = 1'b1;
        if (in_valid) begin
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        timer_d = timer_q + TW'(1);
        if (cmd_done) begin
          code_d      = param_data[CMD_BITS-1:0];
          w_arg_flush = 1'b1;
          grant_d     = 1'b0;
          state_d     = (w_rsp_count != '0) ? ST_RSP_HDR : ST_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Unit went silent: replace its response with a timeout frame
          err_to_d    = 1'b1;
          code_d      = RSP_TIMEOUT;
          w_arg_flush = 1'b1;
          w_rsp_flush = 1'b1;
          grant_d     = 1'b0;
          state_d     = ST_RSP_HDR;
        end else if (param_write) begin
          if (w_rsp_count == RCW'(RSP_DEPTH)) err_ovf_d  = 1'b1;
          else                                w_rsp_push = 1'b1;
        end
      end

      ST_RSP_HDR: begin
        w_out_valid = 1'b1;
        w_out_data  = make_rsp_hdr(8'(w_rsp_count), 32'(code_q));
        if (out_ready) state_d = (w_rsp_count == '0) ? ST_IDLE : ST_RSP_BODY;
      end

      ST_RSP_BODY: begin
        w_out_valid = 1'b1;
        w_out_data  = w_rsp_head;
        if (out_ready) begin
          w_rsp_pop = 1'b1;
          if (w_rsp_count == RCW'(1)) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      cmd_q       <= '0;
      code_q      <= '0;
      cmd_ready_q <= 1'b0;
      grant_q     <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_to_q    <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cmd_q       <= cmd_d;
      code_q      <= code_d;
      cmd_ready_q <= cmd_ready_d;
      grant_q     <= grant_d;
      err_ovf_q   <= err_ovf_d;
      err_to_q    <= err_to_d;
      timer_q     <= timer_d;
    end
  end

  // in_ready is held low while reset is asserted so nothing is accepted
  assign in_ready     = w_in_ready && rst_n;
  assign out_valid    = w_out_valid;
  assign out_data     = w_out_data;
  assign cmd          = cmd_q;
  assign cmd_ready    = cmd_ready_q;
  assign arg_data     = w_arg_head;
  assign invol_grant  = grant_q;
  assign err_overflow = err_ovf_q;
  assign err_timeout  = err_to_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_dispatch
// Purpose  : Directed self-checking bench for cmd_dispatch (TIMEOUT=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_dispatch;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  cmd;
  logic        cmd_ready;
  logic [31:0] arg_data;
  logic        arg_advance;
  logic        cmd_done;
  logic [31:0] param_data;
  logic        param_write;
  logic        invol_req;
  logic        invol_grant;
  logic        err_overflow;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  cmd_dispatch #(
    .CMD_BITS(8), .ARG_DEPTH(16), .RSP_DEPTH(16), .TIMEOUT(10), .RSP_TIMEOUT(8'hff)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cmd(cmd), .cmd_ready(cmd_ready), .arg_data(arg_data), .arg_advance(arg_advance),
    .cmd_done(cmd_done), .param_data(param_data), .param_write(param_write),
    .invol_req(invol_req), .invol_grant(invol_grant),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word and return at the negedge after it was accepted
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_word_wait got in_ready=%0b required 1 (word %h)", in_ready, w);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_param(input logic [31:0] d);
    param_write = 1'b1;
    param_data  = d;
    @(negedge clk);
    param_write = 1'b0;
  endtask

  task automatic finish_cmd(input logic [31:0] code);
    cmd_done   = 1'b1;
    param_data = code;
    @(negedge clk);
    cmd_done   = 1'b0;
  endtask

  // Collect up to n output words with out_ready held high
  task automatic recv_words(input int n, output logic [31:0] w [8], output int got);
    int cyc = 0;
    got = 0;
    for (int i = 0; i < 8; i++) w[i] = '0;
    out_ready = 1'b1;
    while (got < n && cyc < 100) begin
      #1;
      if (out_valid) begin
        w[got] = out_data;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h required 0", out_data); end
    checks++; if ({cmd, cmd_ready, invol_grant} !== 10'h0) begin errors++; $display("FAIL rst_cmd got cmd=%h rdy=%b grant=%b required 0", cmd, cmd_ready, invol_grant); end
    checks++; if (arg_data !== 32'h0) begin errors++; $display("FAIL rst_arg_data got %h required 0", arg_data); end
    checks++; if ({err_overflow, err_timeout} !== 2'b00) begin errors++; $display("FAIL rst_errors got %b%b required 00", err_overflow, err_timeout); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b required 1", in_ready); end
  endtask

  task automatic test_get_version();
    logic [31:0] w [8];
    int got;
    send_word(32'h00000000);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL gv_cmd_ready got %b required 1", cmd_ready); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL gv_in_ready_exec got %b required 0", in_ready); end
    push_param(32'h00000001);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL gv_cmd_ready_pulse got %b required 0", cmd_ready); end
    push_param(32'h04030201);
    push_param(32'h00050010);
    finish_cmd(32'h0);
    recv_words(4, w, got);
    checks++; if (got !== 4) begin errors++; $display("FAIL gv_word_count got %0d required 4", got); end
    checks++; if (w[0] !== 32'h03000000) begin errors++; $display("FAIL gv_hdr got %h required 03000000", w[0]); end
    checks++; if (w[1] !== 32'h00000001) begin errors++; $display("FAIL gv_w1 got %h required 00000001", w[1]); end
    checks++; if (w[2] !== 32'h04030201) begin errors++; $display("FAIL gv_w2 got %h required 04030201", w[2]); end
    checks++; if (w[3] !== 32'h00050010) begin errors++; $display("FAIL gv_w3 got %h required 00050010", w[3]); end
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL gv_idle got valid=%b ready=%b required 0 1", out_valid, in_ready); end
  endtask

  task automatic test_args();
    send_word(32'h02000004);
    send_word(32'h11111111);
    send_word(32'h22222222);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL args_cmd_ready got %b required 1", cmd_ready); end
    checks++; if (cmd !== 8'h04) begin errors++; $display("FAIL args_cmd got %h required 04", cmd); end
    checks++; if (arg_data !== 32'h11111111) begin errors++; $display("FAIL args_arg0 got %h required 11111111", arg_data); end
    arg_advance = 1'b1;
    @(negedge clk);
    checks++; if (arg_data !== 32'h22222222) begin errors++; $display("FAIL args_arg1 got %h required 22222222", arg_data); end
    @(negedge clk);
    checks++; if (arg_data !== 32'h0) begin errors++; $display("FAIL args_empty got %h required 0", arg_data); end
    arg_advance = 1'b0;
    finish_cmd(32'h0);
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL args_no_frame got valid=%b ready=%b required 0 1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [4] = '{32'h03000000, 32'h00000001, 32'h04030201, 32'h00050010};
    logic [31:0] prev = '0;
    bit stalled = 1'b0;
    int got = 0;
    int cyc = 0;
    send_word(32'h00000000);
    push_param(32'h00000001);
    push_param(32'h04030201);
    push_param(32'h00050010);
    finish_cmd(32'h0);
    while (got < 4 && cyc < 100) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      if (out_valid) begin
        if (stalled) begin
          checks++; if (out_data !== prev) begin errors++; $display("FAIL bp_stable got %h required %h", out_data, prev); end
        end
        if (out_ready) begin
          checks++; if (out_data !== exp_w[got]) begin errors++; $display("FAIL bp_word%0d got %h required %h", got, out_data, exp_w[got]); end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev    = out_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    #1;
    checks++; if (got !== 4) begin errors++; $display("FAIL bp_word_count got %0d required 4", got); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_word got valid=%b required 0", out_valid); end
  endtask

  task automatic test_overflow();
    int pulses = 0;
    send_word(32'h14000007);
    for (int i = 0; i < 20; i++) begin
      send_word(32'hA0000000 + 32'(i));
      if (cmd_ready) pulses++;
    end
    @(negedge clk);
    if (cmd_ready) pulses++;
    #1;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL ovf_cmd_ready got %0d pulses required 0", pulses); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b required 1", err_overflow); end
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL ovf_idle got valid=%b ready=%b required 0 1", out_valid, in_ready); end
    send_word(32'h01000009);
    send_word(32'hABCD0001);
    checks++; if ({cmd_ready, cmd} !== {1'b1, 8'h09}) begin errors++; $display("FAIL ovf_next_cmd got rdy=%b cmd=%h required 1 09", cmd_ready, cmd); end
    checks++; if (arg_data !== 32'hABCD0001) begin errors++; $display("FAIL ovf_next_arg got %h required abcd0001", arg_data); end
    finish_cmd(32'h0);
  endtask

  task automatic test_timeout();
    send_word(32'h00000033);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL to_cmd_ready got %b required 1", cmd_ready); end
    push_param(32'hCAFEF00D);
    repeat (8) @(negedge clk);
    checks++; if ({err_timeout, out_valid} !== 2'b00) begin errors++; $display("FAIL to_early got to=%b valid=%b required 0 0", err_timeout, out_valid); end
    @(negedge clk);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b required 1", err_timeout); end
    checks++; if ({out_valid, out_data} !== {1'b1, 32'h000000ff}) begin errors++; $display("FAIL to_frame got valid=%b data=%h required 1 000000ff", out_valid, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL to_one_word got valid=%b required 0", out_valid); end
    finish_cmd(32'h00000005);
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL to_late_done got valid=%b ready=%b required 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_args();
    logic [31:0] w [8];
    int got;
    send_word(32'h03000005);
    send_word(32'h000000A1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++; if ({in_ready, out_valid, cmd_ready, invol_grant, err_overflow, err_timeout} !== 6'b0) begin errors++; $display("FAIL rma_flags got %b%b%b%b%b%b required 000000", in_ready, out_valid, cmd_ready, invol_grant, err_overflow, err_timeout); end
    checks++; if ({cmd, arg_data, out_data} !== 72'h0) begin errors++; $display("FAIL rma_data got cmd=%h arg=%h out=%h required 0", cmd, arg_data, out_data); end
    rst_n = 1'b1;
    @(negedge clk);
    send_word(32'h01000006);
    send_word(32'h5555AAAA);
    checks++; if ({cmd_ready, cmd, arg_data} !== {1'b1, 8'h06, 32'h5555AAAA}) begin errors++; $display("FAIL rma_fresh got rdy=%b cmd=%h arg=%h required 1 06 5555aaaa", cmd_ready, cmd, arg_data); end
    push_param(32'hDEAD0001);
    finish_cmd(32'h00000042);
    recv_words(2, w, got);
    checks++; if ({w[0], w[1]} !== {32'h01000042, 32'hDEAD0001} || got !== 2) begin errors++; $display("FAIL rma_frame got n=%0d %h %h required 2 01000042 dead0001", got, w[0], w[1]); end
  endtask

  task automatic test_invol();
    invol_req = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h00000077;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL inv_in_ready got %b required 0", in_ready); end
    @(negedge clk);
    invol_req = 1'b0;
    #1;
    checks++; if ({invol_grant, cmd_ready, in_ready} !== 3'b100) begin errors++; $display("FAIL inv_grant got grant=%b rdy=%b in_ready=%b required 1 0 0", invol_grant, cmd_ready, in_ready); end
    checks++; if (cmd !== 8'h06) begin errors++; $display("FAIL inv_header_held got cmd=%h required 06", cmd); end
    finish_cmd(32'h0);
    #1;
    checks++; if ({invol_grant, in_ready} !== 2'b01) begin errors++; $display("FAIL inv_release got grant=%b in_ready=%b required 0 1", invol_grant, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({cmd_ready, cmd} !== {1'b1, 8'h77}) begin errors++; $display("FAIL inv_header_run got rdy=%b cmd=%h required 1 77", cmd_ready, cmd); end
    finish_cmd(32'h0);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    arg_advance = 1'b0;
    cmd_done    = 1'b0;
    param_data  = '0;
    param_write = 1'b0;
    invol_req   = 1'b0;
    test_reset();
    test_get_version();
    test_args();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_reset_mid_args();
    test_invol();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmd_dispatch.md
Name: cmd_dispatch

Overview:
Host-side counterpart of the command units. Parses an incoming 32-bit word stream into command frames, buffers the arguments, and presents cmd/cmd_ready/arg_data to the units. It also collects the words each unit streams back on param_data/param_write and emits them as response frames on an outgoing word stream. It handles one command at a time, arbitrates involuntary messages, and enforces a per-command timeout.

Parameters:
CMD_BITS, 8, width of command and response code fields
ARG_DEPTH, 16, argument FIFO depth in words (power of 2)
RSP_DEPTH, 16, response buffer depth in words (power of 2, ≤255)
TIMEOUT, 65535, maximum cycles from cmd_ready to cmd_done
RSP_TIMEOUT, 8'hff, response code emitted on timeout

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_data  in  32  incoming command stream word
in_valid  in  1  in_data valid
in_ready  out  1  in_data accepted when in_valid && in_ready
out_data  out  32  response stream word
out_valid  out  1  out_data valid
out_ready  in  1  out_data consumed when out_valid && out_ready
cmd  out  CMD_BITS  current command; stable from cmd_ready until cmd_done
cmd_ready  out  1  single-cycle pulse: command and all args available
arg_data  out  32  head of the argument FIFO (0 when empty)
arg_advance  in  1  pop argument FIFO head
cmd_done  in  1  unit finished; param_data carries response code this cycle
param_data  in  32  response word, or response code when cmd_done
param_write  in  1  capture param_data as a response word this cycle
invol_req  in  1  unit requests to send an unsolicited message
invol_grant  out  1  grant; held until cmd_done
err_overflow  out  1  sticky: arg or response overflow
err_timeout  out  1  sticky: command timed out

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, both FIFOs emptied, counters 0. Every output is 0, including in_ready, both sticky error flags, cmd and arg_data. Reset aborts any frame in progress and discards its words.
- Command header word: [31:24] nargs, [CMD_BITS-1:0] cmd. The header is followed by nargs argument words.
- States: IDLE, ARGS, DRAIN, EXEC, RSP_HDR, RSP_BODY.
- IDLE: in_ready=1. If invol_req=1, invol_req takes priority: assert invol_grant, set in_ready=0, go to EXEC without pulsing cmd_ready. Otherwise, on header accept, latch cmd and nargs:
  - nargs > ARG_DEPTH: set err_overflow, go to DRAIN.
  - nargs = 0: go to EXEC.
  - otherwise: go to ARGS.
- ARGS: in_ready=1. Push each accepted word. After the nargs-th word, go to EXEC.
- DRAIN: accept and discard nargs words, then return to IDLE. No execution, no response.
- EXEC: in_ready=0. cmd_ready pulses on the first EXEC cycle only, i.e. the cycle after the last argument (or the header when nargs=0) was accepted. arg_data shows argument 0 in that cycle.
- arg_advance: pops when the FIFO is non-empty. The next argument appears on the following cycle, so a unit holding arg_advance=1 reads one argument per cycle. Popping when empty is ignored.
- param_write=1 with cmd_done=0: push param_data into the response buffer.
  - Once the buffer holds RSP_DEPTH words, further words are dropped and err_overflow is set.
  - param_write with cmd_done in the same cycle: cmd_done wins and the word is ignored.
- cmd_done=1:
  - latch param_data[CMD_BITS-1:0] as the response code;
  - flush the remaining arguments;
  - clear invol_grant;
  - if the response count > 0, go to RSP_HDR; otherwise go to IDLE.
- Timeout: a cycle counter starts at the cmd_ready pulse (or at the grant). When it reaches TIMEOUT without cmd_done:
  - set err_timeout;
  - flush the arguments and discard the buffered response;
  - emit a one-word frame with count=0 and code=RSP_TIMEOUT;
  - drop invol_grant;
  - any cmd_done arriving later is ignored.
- Response header: [31:24] count, [CMD_BITS-1:0] code, all other bits 0.
  - RSP_HDR presents the header, then RSP_BODY presents the words in FIFO order.
  - out_data is held stable while out_valid && !out_ready.
  - Return to IDLE after the last word is accepted.
- Unit responses never interleave with other traffic: a new header is not accepted until the response has fully drained.

Decomposition:
- cmd_dispatch_pkg holds: header field positions (NARGS_LSB=24, CODE_LSB=0), the state enum, and the default RSP_TIMEOUT.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH):
  - synchronous push/pop, flush, count, and first-word-fall-through head;
  - instantiated twice: once for arguments, once for the response buffer.

Test Plan:
- Header 0x00000000 (GET_VERSION, 0 args). Stub drives param_write for 3 cycles with words 0x1, 0x04030201, 0x00050010, then cmd_done with param_data=0 -> cmd_ready pulses the cycle after the header; output frame is 0x03000000, 0x1, 0x04030201, 0x00050010.
- Header 0x02000004 with args 0x11111111, 0x22222222. Stub holds arg_advance=1, then cmd_done with code 0 after 2 cycles -> arg_data is 0x11111111 at the cmd_ready cycle and 0x22222222 on the next cycle; no output frame; in_ready returns to 1.
- Same response as the first scenario with out_ready toggled 1,0,0,1,... -> no word lost or duplicated; out_data is stable during stalls.
- Header 0x14000007 (20 args, ARG_DEPTH=16) followed by 20 words -> all 20 words accepted, no cmd_ready pulse, err_overflow=1, no output; the next valid command executes normally.
- TIMEOUT=10, stub never asserts cmd_done -> at cycle 10 after cmd_ready, err_timeout=1 and the output frame is 0x000000ff; a late cmd_done produces nothing.
- rst_n=0 during ARGS, after 1 of 3 args -> all outputs 0 and the FIFO is empty. After release, a fresh command executes correctly; invol_req asserted in IDLE alongside in_valid -> invol_grant wins and the header waits.
